// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Brief    : Plays a register-table melody as a stream of pitch codes.
// Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int  TICK_DIV = 1000,
    parameter int  DEPTH    = 16,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_freq,
    input  logic [7:0]        wr_dur,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [7:0]        frequency_control,
    output logic              playing,
    output logic              note_strobe,
    output logic              done,
    output logic [ADDR_W-1:0] index
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  c_tick_last  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] c_last_index = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    logic [7:0]        r_tab_freq [DEPTH];
    logic [7:0]        r_tab_dur  [DEPTH];

    state_t            r_state,     w_state;
    logic [ADDR_W-1:0] r_index,     w_index;
    logic [7:0]        r_freq,      w_freq;
    logic [7:0]        r_remaining, w_remaining;
    logic [PRE_W-1:0]  r_prescaler, w_prescaler;
    logic              r_strobe,    w_strobe;
    logic              r_done,      w_done;
    logic [7:0]        w_entry_freq;
    logic [7:0]        w_entry_dur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_freq[i] <= '0;
                r_tab_dur[i]  <= '0;
            end
        end else if (wr_en) begin
            r_tab_freq[wr_addr] <= wr_freq;
            r_tab_dur[wr_addr]  <= wr_dur;
        end
    end

    // Register read port: a write this cycle only becomes visible next cycle.
    assign w_entry_freq = r_tab_freq[r_index];
    assign w_entry_dur  = r_tab_dur[r_index];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_freq      <= '0;
            r_remaining <= '0;
            r_prescaler <= '0;
            r_strobe    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_index     <= w_index;
            r_freq      <= w_freq;
            r_remaining <= w_remaining;
            r_prescaler <= w_prescaler;
            r_strobe    <= w_strobe;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_index     = r_index;
        w_freq      = r_freq;
        w_remaining = r_remaining;
        w_prescaler = r_prescaler;
        w_strobe    = 1'b0;
        w_done      = 1'b0;

        if (stop) begin
            w_state     = S_IDLE;
            w_index     = '0;
            w_freq      = '0;
            w_remaining = '0;
            w_prescaler = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state = S_LOAD;
                        w_index = '0;
                    end
                end
                S_LOAD: begin
                    if (w_entry_dur != 8'd0) begin
                        w_freq      = w_entry_freq;
                        w_remaining = w_entry_dur;
                        w_prescaler = '0;
                        w_strobe    = 1'b1;
                        w_state     = S_PLAY;
                    end else if (loop_en && (r_index != '0)) begin
                        w_index = '0;
                    end else begin
                        // Marker on entry 0 always finishes so an empty song cannot spin.
                        w_state = S_IDLE;
                        w_freq  = '0;
                        w_done  = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (r_prescaler == c_tick_last) begin
                        w_prescaler = '0;
                        w_remaining = r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            if (r_index != c_last_index) begin
                                w_index = r_index + 1'b1;
                                w_state = S_LOAD;
                            end else if (loop_en) begin
                                w_index = '0;
                                w_state = S_LOAD;
                            end else begin
                                w_state = S_IDLE;
                                w_freq  = '0;
                                w_done  = 1'b1;
                            end
                        end
                    end else begin
                        w_prescaler = r_prescaler + 1'b1;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign frequency_control = r_freq;
    assign playing           = (r_state != S_IDLE);
    assign note_strobe       = r_strobe;
    assign done              = r_done;
    assign index             = r_index;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_sequencer
// Brief    : Scoreboard bench for note_sequencer with a song-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;
    localparam int TICK  = 4;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_freq = '0;
    logic [7:0] wr_dur  = '0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] frequency_control;
    logic       playing;
    logic       note_strobe;
    logic       done;
    logic [1:0] index;

    note_sequencer #(.TICK_DIV(TICK), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_freq           (wr_freq),
        .wr_dur            (wr_dur),
        .start             (start),
        .stop              (stop),
        .loop_en           (loop_en),
        .frequency_control (frequency_control),
        .playing           (playing),
        .note_strobe       (note_strobe),
        .done              (done),
        .index             (index)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int freq;
        int idx;
        int t;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  m_freq [DEPTH];
    int  m_dur  [DEPTH];
    int  cnt_f  [256];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cur_freq = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input bit is_done, input int f, input int i, input int t);
        ev_t e;
        e.is_done = is_done;
        e.freq    = f;
        e.idx     = i;
        e.t       = t;
        exp_q.push_back(e);
    endtask

    // Walks the song from a start sampled at edge n; events are stamped with
    // the edge after which they are visible, and only those before horizon kept.
    task automatic model_song(input int n, input bit lp, input int horizon);
        int le;
        int idx;
        int fin;
        le  = n + 1;
        idx = 0;
        while (le < horizon) begin
            if (m_dur[idx] != 0) begin
                push_ev(1'b0, m_freq[idx], idx, le);
                fin = le + m_dur[idx] * TICK;
                if (idx == DEPTH - 1) begin
                    if (lp) begin
                        idx = 0;
                        le  = fin + 1;
                    end else begin
                        if (fin < horizon) push_ev(1'b1, 0, 0, fin);
                        break;
                    end
                end else begin
                    idx = idx + 1;
                    le  = fin + 1;
                end
            end else if (lp && idx != 0) begin
                idx = 0;
                le  = le + 1;
            end else begin
                push_ev(1'b1, 0, 0, le);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cnt_f[frequency_control]++;
            if (note_strobe || done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1'b0, int'({note_strobe, done}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", int'({note_strobe, done}) == (mon_e.is_done ? 1 : 2),
                        int'({note_strobe, done}), mon_e.is_done ? 1 : 2);
                    chk("event_time", cyc == mon_e.t, cyc, mon_e.t);
                    if (!mon_e.is_done) begin
                        chk("note_freq", frequency_control == mon_e.freq, frequency_control, mon_e.freq);
                        chk("note_index", index == mon_e.idx, index, mon_e.idx);
                        cur_freq = mon_e.freq;
                    end else begin
                        chk("done_playing_low", playing == 1'b0, playing, 0);
                    end
                end
            end
            if (!playing) cur_freq = 0;
            chk("freq_level", frequency_control == cur_freq, frequency_control, cur_freq);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_entry(input int a, input int f, input int d);
        tick();
        wr_en   = 1'b1;
        wr_addr = a[1:0];
        wr_freq = f[7:0];
        wr_dur  = d[7:0];
        tick();
        wr_en   = 1'b0;
        m_freq[a] = f;
        m_dur[a]  = d;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !playing) return;
            tick();
        end
        chk("wait_idle_timeout", 1'b0, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 256; i++) cnt_f[i] = 0;
    endtask

    // run_len > 0: stop is sampled run_len edges after the start edge.
    task automatic play(input bit lp, input int run_len);
        int n;
        int s;
        tick();
        loop_en = lp;
        start   = 1'b1;
        n = cyc + 1;
        s = (run_len > 0) ? n + run_len : n + 5000;
        model_song(n, lp, s);
        tick();
        start = 1'b0;
        if (run_len > 0) begin
            while (cyc < s - 1) tick();
            stop = 1'b1;
            tick();
            stop = 1'b0;
            chk("stop_freq_zero", frequency_control == 8'd0, frequency_control, 0);
            chk("stop_not_playing", playing == 1'b0, playing, 0);
        end
        wait_idle(6000);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            m_freq[i] = 0;
            m_dur[i]  = 0;
        end
        clear_counts();

        repeat (3) @(posedge clk);
        #2;
        chk("reset_freq", frequency_control == 8'd0, frequency_control, 0);
        chk("reset_playing", playing == 1'b0, playing, 0);
        chk("reset_strobe", note_strobe == 1'b0, note_strobe, 0);
        chk("reset_done", done == 1'b0, done, 0);
        chk("reset_index", index == 2'd0, index, 0);
        reset = 1'b0;

        // Empty table with looping requested must still finish.
        play(1'b1, 0);

        write_entry(0, 16, 2);
        write_entry(1, 2, 1);
        write_entry(2, 0, 0);
        clear_counts();
        play(1'b0, 0);
        chk("freq16_cycles", cnt_f[16] == 9, cnt_f[16], 9);
        chk("freq2_cycles", cnt_f[2] == 5, cnt_f[2], 5);

        play(1'b1, 60);

        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", playing == 1'b0, playing, 0);

        loop_en = 1'b0;
        tick();
        start = 1'b1;
        n = cyc + 1;
        model_song(n, 1'b0, n + 5000);
        tick();
        start = 1'b0;
        while (cyc < n + 5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_play_index", index == 2'd0, index, 0);
        chk("start_in_play_busy", playing == 1'b1, playing, 1);
        wait_idle(6000);

        write_entry(0, 10, 1);
        write_entry(1, 20, 1);
        write_entry(2, 30, 1);
        write_entry(3, 40, 1);
        play(1'b0, 0);
        play(1'b1, 50);

        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                write_entry(a, int'($urandom_range(0, 255)),
                            ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 1) == 1) play(1'b1, int'($urandom_range(10, 120)));
            else play(1'b0, 0);
        end

        // Abort in the middle of a note.
        write_entry(0, 50, 3);
        write_entry(1, 60, 2);
        tick();
        loop_en = 1'b1;
        start   = 1'b1;
        n = cyc + 1;
        model_song(n, 1'b1, n + 5000);
        tick();
        start = 1'b0;
        while (cyc < n + 6) tick();
        reset = 1'b1;
        #1;
        chk("abort_freq", frequency_control == 8'd0, frequency_control, 0);
        chk("abort_playing", playing == 1'b0, playing, 0);
        chk("abort_strobe", note_strobe == 1'b0, note_strobe, 0);
        chk("abort_done", done == 1'b0, done, 0);
        chk("abort_index", index == 2'd0, index, 0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_freq[i] = 0;
            m_dur[i]  = 0;
        end
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("post_reset_idle", playing == 1'b0, playing, 0);
        play(1'b1, 0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
